frame_diff_engine: RTL

Motion-detection core of the frame-difference pipeline. It pops the current camera pixel and the co-located previous-frame pixel from two SDRAM-side read FIFOs, converts both to 8-bit luma, and thresholds their absolute difference. It writes an RGB565 result pixel into the display FIFO that the VGA controller drains. It also counts motion pixels per frame and raises a motion flag.

---
 rtl/frame_diff_pkg.sv | 32 +++
 rtl/frame_diff_engine_if.sv | 25 ++
 rtl/rgb565_to_gray.sv | 36 +++
 rtl/frame_diff_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_diff_pkg.sv
// Shared types and constants for the frame-difference motion pipeline.
package frame_diff_pkg;

  // Frame-level control state of the engine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Output pixel mode; the reserved encoding behaves like pass-through.
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MASK = 2'd1,
    MODE_RED  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // BT.601-style luma weights, scaled by 256 (77 + 150 + 29 = 256).
  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  // RGB565 colour constants used by the output modes.
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] RED565 = 16'hF800;

  // Motion counter width: enough for a full 640x480 frame.
  localparam int CNT_W = 19;

endpackage

// File: rtl/frame_diff_engine_if.sv
// FIFO-side bundle of the frame-difference engine: two legacy read FIFOs
// (current and previous frame) and the display write FIFO.
interface frame_diff_engine_if;
  logic [15:0] cur_data;
  logic        cur_empty;
  logic        cur_rdreq;
  logic [15:0] prev_data;
  logic        prev_empty;
  logic        prev_rdreq;
  logic        out_afull;
  logic        out_wrreq;
  logic [15:0] out_data;

  // Engine side: pops the read FIFOs and pushes the display FIFO.
  modport master (
    input  cur_data, cur_empty, prev_data, prev_empty, out_afull,
    output cur_rdreq, prev_rdreq, out_wrreq, out_data
  );

  // FIFO side: supplies data/status and receives the strobes.
  modport slave (
    output cur_data, cur_empty, prev_data, prev_empty, out_afull,
    input  cur_rdreq, prev_rdreq, out_wrreq, out_data
  );
endinterface

// File: rtl/rgb565_to_gray.sv
// One registered stage converting an RGB565 pixel to 8-bit luma.
module rgb565_to_gray
  import frame_diff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_i,
  output logic [7:0]  y_o
);

  logic [7:0] y_q;

  // Expand each channel to 8 bits by replicating its MSBs, then take the
  // weighted sum. The weights add up to 256, so the 16-bit sum peaks at
  // 65280 and never overflows.
  function automatic logic [7:0] luma(input logic [15:0] p);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {p[15:11], p[15:13]};
    g8  = {p[10:5],  p[10:9]};
    b8  = {p[4:0],   p[4:2]};
    sum = COEF_R * {8'd0, r8} + COEF_G * {8'd0, g8} + COEF_B * {8'd0, b8};
    return 8'(sum >> 8);
  endfunction

  // Register the luma of whatever the FIFO presents; validity is tracked outside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= luma(pix_i);
  end

  assign y_o = y_q;

endmodule

// File: rtl/frame_diff_engine.sv
// Frame-difference motion engine: pops co-located current/previous pixels,
// thresholds their luma difference and writes an RGB565 result pixel four
// cycles after the pop. Also counts motion pixels per frame.
module frame_diff_engine
  import frame_diff_pkg::*;
#(
  parameter int               H_DISP     = 640,
  parameter int               V_DISP     = 480,
  parameter logic [CNT_W-1:0] MOTION_MIN = 19'd2000
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [7:0]           diff_th,
  frame_diff_engine_if.master  fifo,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     motion_cnt,
  output logic                 motion_flag
);

  localparam int XW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int YW = (V_DISP > 1) ? $clog2(V_DISP) : 1;

  // Frame control and pixel position
  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  mode_e          mode_q, mode_d;
  logic [7:0]     th_q, th_d;
  logic           issue;
  logic           first_px;
  logic           last_x;
  logic           last_px;
  mode_e          mode_eff;
  logic [7:0]     th_eff;

  // Pipeline registers; stage N is valid N cycles after the pop
  logic           vld_p1_q, eof_p1_q, prime_p1_q;
  mode_e          mode_p1_q;
  logic [7:0]     th_p1_q;

  logic           vld_p2_q, eof_p2_q, prime_p2_q;
  mode_e          mode_p2_q;
  logic [7:0]     th_p2_q;
  logic [15:0]    pix_p2_q;
  logic [7:0]     ycur_p2;
  logic [7:0]     yprev_p2;
  logic [7:0]     diff_p2;

  logic           vld_p3_q, eof_p3_q, motion_p3_q;
  mode_e          mode_p3_q;
  logic [15:0]    pix_p3_q;

  logic           out_wrreq_q;
  logic [15:0]    out_data_q;
  logic           frame_done_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_tot;
  logic [CNT_W-1:0] motion_cnt_q;
  logic           motion_flag_q;

  // Absolute luma difference, formed as a signed 9-bit subtraction.
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 8'(-d) : 8'(d);
  endfunction

  // Output colour for a pixel; the reserved mode falls through to pass-through.
  function automatic logic [15:0] select_pixel(input mode_e m, input logic mot,
                                               input logic [15:0] pix);
    logic [15:0] r;
    r = pix;
    case (m)
      MODE_MASK: r = mot ? WHITE : BLACK;
      MODE_RED:  r = mot ? RED565 : pix;
      default:   r = pix;
    endcase
    return r;
  endfunction

  assign first_px = (x_q == '0) && (y_q == '0);
  assign last_x   = (x_q == XW'(H_DISP - 1));
  assign last_px  = last_x && (y_q == YW'(V_DISP - 1));

  // Mode and threshold are captured on the first pop of a frame; that pixel
  // itself already uses the freshly sampled values.
  assign mode_eff = first_px ? mode_e'(mode) : mode_q;
  assign th_eff   = first_px ? diff_th : th_q;

  // State, position and per-frame settings registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= MODE_PASS;
      th_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      th_q    <= th_d;
    end
  end

  // Pop decision, raster advance and frame-boundary state transitions.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    th_d    = th_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = PRIME;
      end
      PRIME, RUN: begin
        // out_afull is honoured only here; in-flight pixels always land.
        issue = !fifo.out_afull && !fifo.cur_empty &&
                ((state_q == PRIME) || !fifo.prev_empty);
        if (issue) begin
          if (first_px) begin
            mode_d = mode_e'(mode);
            th_d   = diff_th;
          end
          if (last_x) begin
            x_d = '0;
            y_d = last_px ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          // A frame in progress always completes; en is judged only here.
          if (last_px) state_d = en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo.cur_rdreq  = issue;
  assign fifo.prev_rdreq = issue && (state_q == RUN);

  // Stage 1: FIFO data arrives; tag it with its frame-position and settings.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      eof_p1_q   <= 1'b0;
      prime_p1_q <= 1'b0;
      mode_p1_q  <= MODE_PASS;
      th_p1_q    <= '0;
    end else begin
      vld_p1_q   <= issue;
      eof_p1_q   <= issue && last_px;
      prime_p1_q <= (state_q == PRIME);
      mode_p1_q  <= mode_eff;
      th_p1_q    <= th_eff;
    end
  end

  rgb565_to_gray u_gray_cur (
    .clk   (sys_clk),
    .rst   (rst),
    .pix_i (fifo.cur_data),
    .y_o   (ycur_p2)
  );

  rgb565_to_gray u_gray_prev (
    .clk   (sys_clk),
    .rst   (rst),
    .pix_i (fifo.prev_data),
    .y_o   (yprev_p2)
  );

  // Stage 2: luma registered in the converters; cur pixel delayed alongside.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      eof_p2_q   <= 1'b0;
      prime_p2_q <= 1'b0;
      mode_p2_q  <= MODE_PASS;
      th_p2_q    <= '0;
      pix_p2_q   <= '0;
    end else begin
      vld_p2_q   <= vld_p1_q;
      eof_p2_q   <= eof_p1_q;
      prime_p2_q <= prime_p1_q;
      mode_p2_q  <= mode_p1_q;
      th_p2_q    <= th_p1_q;
      pix_p2_q   <= fifo.cur_data;
    end
  end

  assign diff_p2 = abs_diff(ycur_p2, yprev_p2);

  // Stage 3: strict threshold; the priming frame has no valid previous pixel.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld_p3_q    <= 1'b0;
      eof_p3_q    <= 1'b0;
      motion_p3_q <= 1'b0;
      mode_p3_q   <= MODE_PASS;
      pix_p3_q    <= '0;
    end else begin
      vld_p3_q    <= vld_p2_q;
      eof_p3_q    <= eof_p2_q;
      motion_p3_q <= vld_p2_q && !prime_p2_q && (diff_p2 > th_p2_q);
      mode_p3_q   <= mode_p2_q;
      pix_p3_q    <= pix_p2_q;
    end
  end

  assign acc_tot = acc_q + CNT_W'(motion_p3_q);

  // Stage 4: display write, frame-done pulse and per-frame motion totals.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      out_wrreq_q   <= 1'b0;
      out_data_q    <= '0;
      frame_done_q  <= 1'b0;
      acc_q         <= '0;
      motion_cnt_q  <= '0;
      motion_flag_q <= 1'b0;
    end else begin
      out_wrreq_q  <= vld_p3_q;
      frame_done_q <= vld_p3_q && eof_p3_q;
      if (vld_p3_q) begin
        out_data_q <= select_pixel(mode_p3_q, motion_p3_q, pix_p3_q);
        if (eof_p3_q) begin
          motion_cnt_q  <= acc_tot;
          motion_flag_q <= (acc_tot >= MOTION_MIN);
          acc_q         <= '0;
        end else begin
          acc_q <= acc_tot;
        end
      end
    end
  end

  assign fifo.out_wrreq = out_wrreq_q;
  assign fifo.out_data  = out_data_q;
  assign frame_done     = frame_done_q;
  assign motion_cnt     = motion_cnt_q;
  assign motion_flag    = motion_flag_q;

endmodule
